// File: rtl/popcnt_seq_pkg.sv
// Shared BMU popcount types and default sizing for popcnt_seq.
package popcnt_seq_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} popcnt_state_t;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned CHUNK_DEF = 16;
  localparam int unsigned NCH_FULL  = XLEN_DEF / CHUNK_DEF;
  localparam int unsigned NCH_WORD  = 32 / CHUNK_DEF;
  localparam int unsigned CNTW      = $clog2(NCH_FULL) + 1;

endpackage

// File: rtl/popcntcsa.sv
// Narrow population count over WIDTH bits; synthesis reduces the bit sum to an adder tree.
module popcntcsa #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]       data_i,
  output logic [$clog2(WIDTH):0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + {{($clog2(WIDTH)){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/popcnt_seq.sv
// Iterative cpop/cpopw sequencer: one CHUNK-wide counter reused per cycle.
// Optional early termination on all-zero upper bits: define POPCNT_EARLY_EXIT_EN.
module popcnt_seq
  import popcnt_seq_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [XLEN-1:0]        a,
  input  logic                   word,
  input  logic                   flush,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(XLEN):0]  result,
  output logic                   busy
);

  localparam int unsigned Rw   = $clog2(XLEN) + 1;
  localparam int unsigned Cw   = $clog2(CHUNK) + 1;
  localparam int unsigned NchF = XLEN / CHUNK;
  localparam int unsigned NchW = 32 / CHUNK;
  localparam int unsigned Cntw = $clog2(NchF) + 1;
  localparam logic [XLEN-1:0] WordMask = XLEN'(32'hFFFF_FFFF);

  popcnt_state_t   state_q, state_d;
  logic [Rw-1:0]   acc_q, acc_d;
  logic [Rw-1:0]   result_q, result_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [Cntw-1:0] cnt_q, cnt_d;
  logic [Cw-1:0]   chunk_cnt;
  logic [Rw-1:0]   sum;
  logic            word_eff;
  logic            last;

  // cpopw only exists on RV64; on a 32-bit datapath the flag is meaningless.
  assign word_eff = (XLEN > 32) ? word : 1'b0;

  popcntcsa #(
    .WIDTH(CHUNK)
  ) u_csa (
    .data_i (shreg_q[CHUNK-1:0]),
    .count_o(chunk_cnt)
  );

  assign sum = acc_q + Rw'(chunk_cnt);

`ifdef POPCNT_EARLY_EXIT_EN
  assign last = (cnt_q == '0) || ((shreg_q >> CHUNK) == '0);
`else
  assign last = (cnt_q == '0);
`endif

  assign req_ready  = reset && (state_q == IDLE) && !flush;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign result     = result_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          shreg_d = word_eff ? (a & WordMask) : a;
          acc_d   = '0;
          cnt_d   = word_eff ? Cntw'(NchW - 1) : Cntw'(NchF - 1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (flush) begin
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = sum;
          shreg_d = shreg_q >> CHUNK;
          cnt_d   = cnt_q - Cntw'(1);
          if (last) begin
            result_d = sum;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flush) begin
          acc_d   = '0;
          state_d = IDLE;
        end else if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
